ps2_symbol_transmitter: RTL and testbench
=========================================

// Module: ps2_symbol_transmitter
// PURPOSE
//  Device-side PS/2 keyboard emulator. Accepts a 6-bit symbol index (0-9 = digits, 10-35 = A-Z),
//  encodes it to its Set-2 make code, and serialises make [+ F0 + make] on open-collector PS/2
//  lines, generating the PS/2 clock itself. Encoder counterpart of the scan-code/seven-segment
//  decoder: drives the keyboard input path in loopback tests and in self-play mode.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency
//  PS2_CLK_HZ   12_500      generated PS/2 clock; HALF = CLK_FREQ_HZ/(2*PS2_CLK_HZ) cycles per phase
//  GAP_CYCLES   50_000      idle time (lines released) after every byte and after inhibit release
//  SEND_BREAK   1           1: send make, F0, make; 0: send make only
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  synchronous, active-low reset
//  symbol       in   6  symbol index, sampled on accept
//  send         in   1  request; accepted when send && ready
//  ready        out  1  1 in IDLE only
//  done         out  1  1-cycle pulse when the full sequence (incl. final gap) completes
//  err          out  1  1-cycle pulse when an accepted symbol is >= 36
//  ps2_clk_in   in   1  synchronised PS/2 clock line (host-inhibit detection)
//  ps2_clk_oe   out  1  1 = pull PS/2 clock low; 0 = release
//  ps2_dat_oe   out  1  1 = pull PS/2 data low; 0 = release
// BEHAVIOUR
//  Reset (resetn=0 at posedge, any state): state IDLE, ready=1, done=0, err=0, ps2_clk_oe=0, ps2_dat_oe=0,
//   all counters and byte index cleared; an in-progress frame is abandoned immediately.
//  Encoding table (index: code): 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46 10:1C 11:32
//   12:21 13:23 14:24 15:2B 16:34 17:33 18:43 19:3B 20:42 21:4B 22:3A 23:31 24:44 25:4D 26:15
//   27:2D 28:1B 29:2C 30:3C 31:2A 32:1D 33:22 34:35 35:1A. Index 36-63 is invalid.
//  Accept: send && ready at a posedge -> symbol registered, ready=0 next cycle. If invalid: err pulses
//   on the next cycle, ready returns 1 the cycle after, lines never driven, done not pulsed.
//   send while ready=0 is ignored (not queued).
//  Byte list: SEND_BREAK=1 -> {make, F0, make}; 0 -> {make}.
//  Frame per byte: 11 bits LSB-first: start 0, d0..d7, odd parity (^d ? 0 : 1), stop 1.
//  States: IDLE -> BIT_HI -> BIT_LO -> (next bit: BIT_HI | after stop: GAP) -> next byte BIT_HI | IDLE.
//   BIT_HI: HALF cycles, ps2_clk_oe=0, ps2_dat_oe=~bit (set on entry, stable whole bit).
//   BIT_LO: HALF cycles, ps2_clk_oe=1, data unchanged. Host samples on falling clock edge.
//   GAP: GAP_CYCLES cycles, both lines released. One byte = 22*HALF cycles + GAP_CYCLES.
//  done pulses the cycle GAP of the last byte ends (same edge ready rises).
//  Inhibit: on the last cycle of any BIT_HI, if ps2_clk_in=0 (host holding clock) -> release both
//   lines, enter INHIBIT; stay while ps2_clk_in=0; then GAP, then resend the current byte from the start
//   bit (earlier completed bytes not resent). Not checked during BIT_LO (we drive the line).
//  Counters: phase counter width $clog2(max(HALF,GAP_CYCLES)+1); bit index 0..10; byte index 0..2.
// TESTING (CLK_FREQ_HZ=1000, PS2_CLK_HZ=100 -> HALF=5, GAP_CYCLES=20, ps2_clk_in=1 unless stated)
//  T1 symbol=0, send 1 cycle -> bytes 45,F0,45; 0x45 frame dat bits 0,1,0,1,0,0,0,1,0,par 0,stop 1;
//     F0 parity 1; done after 3*(110+20) cycles from accept; ready=0 throughout.
//  T2 symbol=35, SEND_BREAK=0 -> single frame of 0x1A (parity 0), done once, ready back to 1.
//  T3 symbol=36 -> err pulse 1 cycle, no done, ps2_clk_oe/ps2_dat_oe stay 0, ready=1 within 2 cycles.
//  T4 hold ps2_clk_in=0 during bit 4 of F0 for 30 cycles -> lines released, INHIBIT, 20-cycle gap,
//     F0 resent from start bit, then final 45; only 3 complete frames decoded.
//  T5 pulse send again mid-frame with symbol=1 -> ignored; sequence for original symbol unchanged.
//  T6 resetn=0 for 1 cycle mid-bit -> next cycle both oe=0, ready=1; new send=10 -> clean 1C,F0,1C.

Source files
------------

// File: rtl/ps2_symbol_transmitter.sv
// Device-side PS/2 keyboard emulator: encodes a symbol index (0-9, A-Z) to its Set-2 make code
// and sends make [+ F0 + make] as device-clocked PS/2 frames on open-collector lines.
module ps2_symbol_transmitter #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int PS2_CLK_HZ  = 12_500,
    parameter int GAP_CYCLES  = 50_000,
    parameter int SEND_BREAK  = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] symbol,
    input  logic       send,
    output logic       ready,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int HALF = CLK_FREQ_HZ / (2 * PS2_CLK_HZ);
    localparam int MAXC = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [1:0] LAST_BYTE = (SEND_BREAK != 0) ? 2'd2 : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP,
        S_INHIBIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    make_q, make_d;
    logic          done_q, done_d;

    logic [8:0]    sym_enc;
    logic [7:0]    cur_byte;
    logic [15:0]   frame;
    logic          cur_bit;
    logic          half_end;
    logic          gap_end;

    // Returns {valid, make_code}; indices 36..63 have no key.
    function automatic logic [8:0] encode(input logic [5:0] s);
        case (s)
            6'd0:  encode = {1'b1, 8'h45};
            6'd1:  encode = {1'b1, 8'h16};
            6'd2:  encode = {1'b1, 8'h1E};
            6'd3:  encode = {1'b1, 8'h26};
            6'd4:  encode = {1'b1, 8'h25};
            6'd5:  encode = {1'b1, 8'h2E};
            6'd6:  encode = {1'b1, 8'h36};
            6'd7:  encode = {1'b1, 8'h3D};
            6'd8:  encode = {1'b1, 8'h3E};
            6'd9:  encode = {1'b1, 8'h46};
            6'd10: encode = {1'b1, 8'h1C};
            6'd11: encode = {1'b1, 8'h32};
            6'd12: encode = {1'b1, 8'h21};
            6'd13: encode = {1'b1, 8'h23};
            6'd14: encode = {1'b1, 8'h24};
            6'd15: encode = {1'b1, 8'h2B};
            6'd16: encode = {1'b1, 8'h34};
            6'd17: encode = {1'b1, 8'h33};
            6'd18: encode = {1'b1, 8'h43};
            6'd19: encode = {1'b1, 8'h3B};
            6'd20: encode = {1'b1, 8'h42};
            6'd21: encode = {1'b1, 8'h4B};
            6'd22: encode = {1'b1, 8'h3A};
            6'd23: encode = {1'b1, 8'h31};
            6'd24: encode = {1'b1, 8'h44};
            6'd25: encode = {1'b1, 8'h4D};
            6'd26: encode = {1'b1, 8'h15};
            6'd27: encode = {1'b1, 8'h2D};
            6'd28: encode = {1'b1, 8'h1B};
            6'd29: encode = {1'b1, 8'h2C};
            6'd30: encode = {1'b1, 8'h3C};
            6'd31: encode = {1'b1, 8'h2A};
            6'd32: encode = {1'b1, 8'h1D};
            6'd33: encode = {1'b1, 8'h22};
            6'd34: encode = {1'b1, 8'h35};
            6'd35: encode = {1'b1, 8'h1A};
            default: encode = 9'h000;
        endcase
    endfunction

    assign sym_enc  = encode(symbol);
    assign cur_byte = (byte_idx_q == 2'd1) ? 8'hF0 : make_q;
    assign frame    = {5'b00000, 1'b1, ~^cur_byte, cur_byte, 1'b0};
    assign cur_bit  = frame[bit_idx_q];
    assign half_end = (cnt_q == CW'(HALF - 1));
    assign gap_end  = (cnt_q == CW'(GAP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            byte_idx_q <= 2'd0;
            make_q     <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            make_q     <= make_d;
            done_q     <= done_d;
        end
    end

    // After a normal stop bit bit_idx stays at 10; an inhibit clears it to 0,
    // which is how GAP tells "advance to next byte" from "resend this byte".
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        make_d     = make_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (send) begin
                    make_d     = sym_enc[7:0];
                    bit_idx_d  = 4'd0;
                    byte_idx_d = 2'd0;
                    state_d    = sym_enc[8] ? S_BIT_HI : S_ERR;
                end
            end
            S_ERR: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            S_BIT_HI: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (!ps2_clk_in) begin
                        bit_idx_d = 4'd0;
                        state_d   = S_INHIBIT;
                    end else begin
                        state_d = S_BIT_LO;
                    end
                end
            end
            S_BIT_LO: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd10) begin
                        state_d = S_GAP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        state_d   = S_BIT_HI;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    cnt_d = '0;
                    if (bit_idx_q != 4'd10) begin
                        state_d = S_BIT_HI;
                    end else if (byte_idx_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        bit_idx_d  = 4'd0;
                        state_d    = S_BIT_HI;
                    end
                end
            end
            S_INHIBIT: begin
                cnt_d = '0;
                if (ps2_clk_in) begin
                    state_d = S_GAP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ready      = (state_q == S_IDLE);
        err        = (state_q == S_ERR);
        done       = done_q;
        ps2_clk_oe = (state_q == S_BIT_LO);
        ps2_dat_oe = ((state_q == S_BIT_HI) || (state_q == S_BIT_LO)) && !cur_bit;
    end

endmodule

// File: tb/tb_ps2_symbol_transmitter.sv
// Bench for ps2_symbol_transmitter: a host-side monitor decodes frames off the lines and
// compares them against a queue of bytes predicted from the Set-2 table.
module tb_ps2_symbol_transmitter;

    localparam int CLK_HZ = 1000;
    localparam int PS2_HZ = 100;
    localparam int GAP    = 20;
    localparam int HALF   = CLK_HZ / (2 * PS2_HZ);
    localparam int LAT3   = 3 * (22 * HALF + GAP);
    localparam int LAT1   = 22 * HALF + GAP;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       b_clk_in = 1'b1;
    logic [5:0] a_symbol = 6'd0, b_symbol = 6'd0;
    logic       a_send = 1'b0, b_send = 1'b0;
    logic       a_ready, a_done, a_err, a_clk_oe, a_dat_oe;
    logic       b_ready, b_done, b_err, b_clk_oe, b_dat_oe;

    always #5 clk = ~clk;

    ps2_symbol_transmitter #(.CLK_FREQ_HZ(CLK_HZ), .PS2_CLK_HZ(PS2_HZ), .GAP_CYCLES(GAP),
                             .SEND_BREAK(1)) dut_a (
        .clk(clk), .resetn(resetn), .symbol(a_symbol), .send(a_send), .ready(a_ready),
        .done(a_done), .err(a_err), .ps2_clk_in(ps2_clk_in), .ps2_clk_oe(a_clk_oe),
        .ps2_dat_oe(a_dat_oe));

    ps2_symbol_transmitter #(.CLK_FREQ_HZ(CLK_HZ), .PS2_CLK_HZ(PS2_HZ), .GAP_CYCLES(GAP),
                             .SEND_BREAK(0)) dut_b (
        .clk(clk), .resetn(resetn), .symbol(b_symbol), .send(b_send), .ready(b_ready),
        .done(b_done), .err(b_err), .ps2_clk_in(b_clk_in), .ps2_clk_oe(b_clk_oe),
        .ps2_dat_oe(b_dat_oe));

    logic [7:0] make_tab [0:35] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    logic [7:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: host view of the selected DUT; a bit is sampled where the clock line falls.
    logic        mon_sel = 1'b0;
    logic        mon_clk_oe, mon_dat_oe, mon_ready;
    logic        mon_prev = 1'b0;
    logic [10:0] mon_frame = '0;
    int          mon_bits = 0;
    int          mon_frames = 0;

    assign mon_clk_oe = mon_sel ? b_clk_oe : a_clk_oe;
    assign mon_dat_oe = mon_sel ? b_dat_oe : a_dat_oe;
    assign mon_ready  = mon_sel ? b_ready  : a_ready;

    always @(negedge clk) begin : monitor
        logic [10:0] fr;
        int          ones;
        mon_prev <= mon_clk_oe;
        if (mon_ready || !ps2_clk_in) begin
            mon_bits <= 0;
        end else if (mon_clk_oe && !mon_prev) begin
            fr = mon_frame;
            fr[mon_bits] = ~mon_dat_oe;
            mon_frame <= fr;
            if (mon_bits == 10) begin
                ones = 0;
                for (int i = 1; i <= 9; i++) ones += fr[i];
                check("start_bit", fr[0], 1'b0);
                check("stop_bit", fr[10], 1'b1);
                check("odd_parity", ones % 2, 1);
                if (exp_q.size() == 0) check("unexpected_frame", fr[8:1], 32'hFFFF_FFFF);
                else check("frame_byte", fr[8:1], exp_q.pop_front());
                mon_bits   <= 0;
                mon_frames <= mon_frames + 1;
            end else begin
                mon_bits <= mon_bits + 1;
            end
        end
    end

    int a_done_cnt = 0, b_done_cnt = 0, a_err_cnt = 0, b_err_cnt = 0;
    always @(negedge clk) begin
        a_done_cnt <= a_done_cnt + int'(a_done);
        b_done_cnt <= b_done_cnt + int'(b_done);
        a_err_cnt  <= a_err_cnt + int'(a_err);
        b_err_cnt  <= b_err_cnt + int'(b_err);
    end

    int a_done_exp = 0, b_done_exp = 0, a_err_exp = 0, b_err_exp = 0;

    function automatic logic cur_ready(input bit b); return b ? b_ready : a_ready; endfunction
    function automatic logic cur_done(input bit b);  return b ? b_done  : a_done;  endfunction
    function automatic logic cur_err(input bit b);   return b ? b_err   : a_err;   endfunction
    function automatic logic cur_lines(input bit b);
        return b ? (b_clk_oe | b_dat_oe) : (a_clk_oe | a_dat_oe);
    endfunction

    // Predict the byte list, then present the symbol for one cycle; returns at the
    // negedge just after the accepting posedge.
    task automatic issue(input bit b, input logic [5:0] sym);
        mon_sel = b;
        if (sym < 36) begin
            exp_q.push_back(make_tab[sym]);
            if (!b) begin
                exp_q.push_back(8'hF0);
                exp_q.push_back(make_tab[sym]);
            end
        end
        @(negedge clk);
        if (b) begin b_symbol = sym; b_send = 1'b1; end
        else   begin a_symbol = sym; a_send = 1'b1; end
        @(negedge clk);
        a_send = 1'b0; b_send = 1'b0;
        a_symbol = 6'($urandom); b_symbol = 6'($urandom);
    endtask

    task automatic wait_done(input bit b, input int exp_lat);
        bit got = 1'b0;
        bit ready_hi = 1'b0;
        int lat = 0;
        for (int n = 1; n <= 3000 && !got; n++) begin
            @(negedge clk);
            if (cur_done(b)) begin got = 1'b1; lat = n; end
            else if (cur_ready(b)) ready_hi = 1'b1;
        end
        check("done_seen", got, 1'b1);
        if (got && exp_lat >= 0) check("done_latency", lat, exp_lat);
        check("ready_low_while_busy", ready_hi, 1'b0);
        check("ready_at_done", cur_ready(b), 1'b1);
        check("frames_pending", exp_q.size(), 0);
        if (b) b_done_exp++; else a_done_exp++;
        @(negedge clk);
        check("done_one_cycle", cur_done(b), 1'b0);
    endtask

    task automatic run_invalid(input bit b, input logic [5:0] sym);
        bit quiet = 1'b1;
        issue(b, sym);
        check("err_pulse", cur_err(b), 1'b1);
        check("ready_low_on_err", cur_ready(b), 1'b0);
        if (b) b_err_exp++; else a_err_exp++;
        @(negedge clk);
        check("err_one_cycle", cur_err(b), 1'b0);
        check("ready_after_err", cur_ready(b), 1'b1);
        for (int n = 0; n < 8; n++) begin
            if (cur_lines(b) || cur_done(b)) quiet = 1'b0;
            @(negedge clk);
        end
        check("lines_quiet_on_err", quiet, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int  start_frames;
        bit  found;
        logic [5:0] s;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check("reset_ready_a", a_ready, 1'b1);
        check("reset_ready_b", b_ready, 1'b1);
        check("reset_lines_a", {a_clk_oe, a_dat_oe, a_done, a_err}, 4'b0000);
        check("reset_lines_b", {b_clk_oe, b_dat_oe, b_done, b_err}, 4'b0000);

        // make/break of '0' and single make of 'Z'
        issue(1'b0, 6'd0);
        wait_done(1'b0, LAT3);
        issue(1'b1, 6'd35);
        wait_done(1'b1, LAT1);
        run_invalid(1'b0, 6'd36);

        // host inhibit during bit 4 of the F0 byte
        start_frames = mon_frames;
        issue(1'b0, 6'd0);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (mon_frames == start_frames + 1 && mon_bits == 4 && !a_clk_oe) found = 1'b1;
        end
        check("inhibit_point_found", found, 1'b1);
        ps2_clk_in = 1'b0;
        repeat (30) @(negedge clk);
        check("inhibit_lines_released", {a_clk_oe, a_dat_oe}, 2'b00);
        check("inhibit_not_ready", a_ready, 1'b0);
        ps2_clk_in = 1'b1;
        wait_done(1'b0, -1);
        check("inhibit_frame_count", mon_frames - start_frames, 3);

        // send while busy is ignored
        issue(1'b0, 6'($urandom_range(0, 35)));
        repeat (50) @(negedge clk);
        a_symbol = 6'd1; a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        wait_done(1'b0, LAT3 - 51);

        // reset in the middle of a bit, then a clean sequence
        issue(1'b0, 6'($urandom_range(0, 35)));
        repeat (37) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        check("midreset_lines", {a_clk_oe, a_dat_oe}, 2'b00);
        check("midreset_ready", a_ready, 1'b1);
        issue(1'b0, 6'd10);
        wait_done(1'b0, LAT3);

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0, 1: begin issue(1'b0, 6'($urandom_range(0, 35))); wait_done(1'b0, LAT3); end
                2:    begin issue(1'b1, 6'($urandom_range(0, 35))); wait_done(1'b1, LAT1); end
                default: begin
                    s = 6'($urandom_range(36, 63));
                    run_invalid(1'($urandom_range(0, 1)), s);
                end
            endcase
        end

        repeat (3) @(negedge clk);
        check("total_done_a", a_done_cnt, a_done_exp);
        check("total_done_b", b_done_cnt, b_done_exp);
        check("total_err_a", a_err_cnt, a_err_exp);
        check("total_err_b", b_err_cnt, b_err_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
